// File: rtl/lp_filter_scheduler.sv
// Shared-datapath low-pass filter engine: per-channel sample latching, round-robin
// grant, and a cascade of first-order IIR stages evaluated one stage per clock.
module lp_filter_scheduler #(
    parameter int CHANNELS   = 4,
    parameter int CH_BITS    = 2,
    parameter int DATA_BITS  = 28,
    parameter int SHIFT_BITS = 2,
    parameter int STAGES     = 2
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            CE,
    input  logic [CHANNELS-1:0]             IN_VALID,
    input  logic [CHANNELS*DATA_BITS-1:0]   IN_VALUE,
    output logic                            OUT_VALID,
    output logic [CH_BITS-1:0]              OUT_CHANNEL,
    output logic [DATA_BITS-1:0]            OUT_VALUE,
    output logic                            BUSY,
    output logic [CHANNELS-1:0]             OVERRUN
);

    localparam int INTERNAL = DATA_BITS + SHIFT_BITS;
    localparam int S_BITS   = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [CHANNELS-1:0]   pend;
    logic [DATA_BITS-1:0]  hold [CHANNELS];
    logic [CH_BITS-1:0]    last_grant;
    logic [CH_BITS-1:0]    ch_p0;
    logic [S_BITS-1:0]     s_p0;
    logic [DATA_BITS-1:0]  x_p0;
    logic [INTERNAL-1:0]   st [CHANNELS][STAGES];

    logic                  gnt_any;
    logic [CH_BITS-1:0]    gnt_ch;
    logic [CH_BITS-1:0]    idx;
    logic                  grant;
    logic                  last_stage;
    logic [INTERNAL-1:0]   st_new;

    // One IIR stage: state + (x - state/2^SHIFT), wrapping modulo 2^INTERNAL.
    function automatic logic [INTERNAL-1:0] stage_next(input logic [INTERNAL-1:0]  t,
                                                       input logic [DATA_BITS-1:0] x);
        logic signed [DATA_BITS:0]  d;
        logic signed [INTERNAL-1:0] d_ext;
        d     = $signed({1'b0, x}) - $signed({1'b0, t[INTERNAL-1:SHIFT_BITS]});
        d_ext = INTERNAL'(d);
        return t + $unsigned(d_ext);
    endfunction

    // Search starts just after the last granted channel and wraps around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = last_grant + CH_BITS'(i);
            if (!gnt_any && pend[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    assign last_stage = (s_p0 == S_BITS'(STAGES - 1));
    assign st_new     = stage_next(st[ch_p0][s_p0], x_p0);
    assign BUSY       = (fsm_q == RUN);

    always_comb begin
        fsm_d = fsm_q;
        grant = 1'b0;
        case (fsm_q)
            IDLE: if (gnt_any) begin
                fsm_d = RUN;
                grant = 1'b1;
            end
            RUN:  if (last_stage) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fsm_q       <= IDLE;
            pend        <= '0;
            OVERRUN     <= '0;
            last_grant  <= CH_BITS'(CHANNELS - 1);
            ch_p0       <= '0;
            s_p0        <= '0;
            OUT_VALID   <= 1'b0;
            OUT_CHANNEL <= '0;
            OUT_VALUE   <= '0;
            for (int c = 0; c < CHANNELS; c++)
                for (int s = 0; s < STAGES; s++)
                    st[c][s] <= '0;
        end else if (CE) begin
            fsm_q     <= fsm_d;
            OUT_VALID <= 1'b0;
            // grant: operand load, stage 0 next
            if (grant) begin
                pend[gnt_ch] <= 1'b0;
                last_grant   <= gnt_ch;
                ch_p0        <= gnt_ch;
                s_p0         <= '0;
                x_p0         <= hold[gnt_ch];
            end
            // stage evaluation: result of stage s feeds stage s+1
            if (fsm_q == RUN) begin
                st[ch_p0][s_p0] <= st_new;
                x_p0            <= st_new[INTERNAL-1:SHIFT_BITS];
                s_p0            <= s_p0 + S_BITS'(1);
                if (last_stage) begin
                    OUT_VALID   <= 1'b1;
                    OUT_CHANNEL <= ch_p0;
                    OUT_VALUE   <= st_new[INTERNAL-1:SHIFT_BITS];
                end
            end
            // A sample arriving in its own grant cycle is kept pending, not an overrun.
            for (int c = 0; c < CHANNELS; c++) begin
                if (IN_VALID[c]) begin
                    pend[c] <= 1'b1;
                    if (pend[c] && !(grant && gnt_ch == CH_BITS'(c)))
                        OVERRUN[c] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CE) begin
            for (int c = 0; c < CHANNELS; c++)
                if (IN_VALID[c]) hold[c] <= IN_VALUE[c*DATA_BITS +: DATA_BITS];
        end
    end

endmodule

// File: doc/lp_filter_scheduler.md
Name: lp_filter_scheduler

Overview:
Time-multiplexed low-pass filter engine shared by CHANNELS sensor channels. Each channel has a cascade of STAGES first-order IIR stages: state += in - (state >> SHIFT_BITS). The block latches incoming samples per channel and grants pending channels round-robin. It runs the stages one per clock on a single shared adder datapath, with per-channel state held in registers, and emits a tagged filtered result. It sits between the per-channel frequency/period measurement outputs and the downstream sensor value consumer.

Parameters:
CHANNELS, 4, number of input channels; power of two, 2..16.
CH_BITS, 2, channel index width; must equal log2(CHANNELS).
DATA_BITS, 28, input/output sample width, unsigned.
SHIFT_BITS, 2, filter coefficient: alpha = 2^-SHIFT_BITS.
STAGES, 2, cascaded filter stages per channel, 1..8.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active high
CE  in  1  clock enable; 0 freezes all state, and IN_VALID is ignored
IN_VALID  in  CHANNELS  per-channel one-cycle sample strobe
IN_VALUE  in  CHANNELS*DATA_BITS  packed samples; channel c occupies bits [c*DATA_BITS +: DATA_BITS]
OUT_VALID  out  1  one-cycle result strobe
OUT_CHANNEL  out  CH_BITS  channel of current result
OUT_VALUE  out  DATA_BITS  filtered value
BUSY  out  1  FSM not IDLE
OVERRUN  out  CHANNELS  sticky per-channel flag: a pending sample was overwritten

Behaviour:
- Reset values: all stage states 0; pending flags 0; OVERRUN 0; OUT_VALID 0; OUT_CHANNEL 0; OUT_VALUE 0; BUSY 0; FSM in IDLE.
- Reset behaviour: last_grant resets to CHANNELS-1, so channel 0 has top priority first. Reset mid-operation aborts the current pass and discards pending samples.
- Capture: when CE=1 and IN_VALID[c]=1, latch IN_VALUE slice c into hold[c] and set pend[c].
- Overrun: if pend[c] is already set and channel c is not being granted in the same cycle, set OVERRUN[c] and overwrite hold[c] with the new sample.
- Capture coinciding with grant: the grant consumes the old hold[c]. The new sample is latched and pend[c] stays set. No overrun is flagged.
- IDLE state:
  - If any pend bit is set, select the first pending channel searching from last_grant+1 upward with wrap-around.
  - Load operand x = hold[ch], clear pend[ch], set stage index s = 0, update last_grant, and go to RUN.
  - If no pend bit is set, remain in IDLE.
- RUN state, one stage per CE cycle:
  - t = state[ch][s]
  - d = x - t[INTERNAL-1:SHIFT_BITS], a signed DATA_BITS+1-bit value
  - state[ch][s] <= t + sign_extend(d), with INTERNAL = DATA_BITS + SHIFT_BITS, wrapping modulo 2^INTERNAL
  - x <= new_state[INTERNAL-1:SHIFT_BITS], which feeds the next stage
  - s increments each cycle.
- Pass completion: on s = STAGES-1, the next cycle asserts OUT_VALID=1 for exactly one cycle, with OUT_CHANNEL = ch and OUT_VALUE = x of the final stage. The FSM returns to IDLE in that same cycle and may grant again in it.
- Held outputs: OUT_CHANNEL and OUT_VALUE hold their last result while OUT_VALID=0.
- Timing: from the IN_VALID cycle to OUT_VALID is STAGES+2 cycles when idle. Peak throughput is one sample per STAGES+1 cycles.
- BUSY is 1 in every RUN cycle and 0 in IDLE.
- CE=0: every register holds its value, including an OUT_VALID pulse, which stays high until the next CE=1 edge.
- Arithmetic range: with unsigned inputs the state never leaves [0, 2^INTERNAL). Wrap is specified only for determinism.
- Isolation: channels never share state. Granting channel c reads and writes only state[c][*].

Test Plan:
- Config for all scenarios: DATA_BITS=16, SHIFT_BITS=2, STAGES=2, CHANNELS=4.
- Single sample, ch0: IN_VALUE=1000, one pulse at cycle 0 -> OUT_VALID at cycle 4 with OUT_CHANNEL=0, OUT_VALUE=62. Stage states are 1000 and 250.
- Repeat sample, ch0: a second 1000 after the first completes -> OUT_VALUE=156. Stage states are 1750 and 625. A steady 1000 input converges to exactly 1000 within 100 samples.
- Round-robin: IN_VALID=4'b1111 in one cycle with values 100/200/300/400 -> four results in order ch0, ch1, ch2, ch3, spaced 3 cycles apart, with OUT_VALUE 6, 12, 18, 25. OVERRUN stays 0.
- Overrun: while ch1 is pending behind a busy ch0, pulse ch1 twice with values 7 then 9 -> OVERRUN[1]=1 and ch1 is filtered with 9. Separately, a pulse landing exactly in the grant cycle -> both samples are processed and no overrun is flagged.
- CE and reset: drop CE for 5 cycles mid-RUN -> OUT_VALID is delayed by exactly 5 cycles with an unchanged value. Assert RESET mid-RUN -> no OUT_VALID follows, and all outputs and OVERRUN are 0. The next ch2 sample of 1000 yields 62, confirming the state was cleared.
